// File: rtl/wish_blinky_multi.sv
// Wishbone-controlled bank of pattern LEDs: a shared prescaler tick rotates each
// enabled channel's mask and drives its outgoing bit, in LOOP or ONESHOT mode.
module wish_blinky_multi #(
  parameter int CH_BITS   = 2,
  parameter int MASK_BITS = 8,
  parameter int DIV_BITS  = 22,
  parameter int DIV_TOP   = 2**22-1
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  STB_I,
  input  logic                  WE_I,
  input  logic [CH_BITS:0]      ADR_I,
  input  logic [MASK_BITS-1:0]  DAT_I,
  output logic [MASK_BITS-1:0]  DAT_O,
  output logic                  ACK_O,
  output logic [2**CH_BITS-1:0] o_led
);
  localparam int NUM_CH = 2**CH_BITS;
  localparam int POS_W  = $clog2(MASK_BITS) + 1;
  localparam logic [DIV_BITS-1:0] TOP      = DIV_BITS'(DIV_TOP);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(MASK_BITS - 1);
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_LOOP = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;

  logic [DIV_BITS-1:0] cnt;
  logic                tick;
  logic                acc, wr, sel;
  logic [CH_BITS-1:0]  ch;
  logic [MASK_BITS-1:0] rd_data;

  logic [NUM_CH-1:0][MASK_BITS-1:0] shift_all;
  logic [NUM_CH-1:0][1:0]           mode_all;
  logic [NUM_CH-1:0]                done_all;

  assign tick = (cnt == TOP);
  assign acc  = STB_I & ~ACK_O;
  assign wr   = acc & WE_I;
  assign sel  = ADR_I[CH_BITS];
  assign ch   = ADR_I[CH_BITS-1:0];

  // Free-running prescaler; bus traffic never restarts it.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) cnt <= '0;
    else       cnt <= tick ? '0 : cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [MASK_BITS-1:0] shift;
    logic [1:0]           mode;
    logic [POS_W-1:0]     pos;
    logic                 done, led, wr_mask, wr_mode, step;

    assign wr_mask = wr && !sel && (ch == CH_BITS'(i));
    assign wr_mode = wr &&  sel && (ch == CH_BITS'(i));
    assign step    = tick && ((mode == MODE_LOOP) || (mode == MODE_ONE && !done));

    // Bus writes take priority over a coincident tick for this channel only.
    always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
        shift <= '0;
        mode  <= MODE_OFF;
        pos   <= '0;
        done  <= 1'b0;
        led   <= 1'b0;
      end else if (wr_mask) begin
        shift <= DAT_I;
        pos   <= '0;
        done  <= 1'b0;
        led   <= 1'b0;
      end else if (wr_mode) begin
        mode <= DAT_I[1:0];
        pos  <= '0;
        done <= 1'b0;
        if (DAT_I[1:0] != MODE_LOOP && DAT_I[1:0] != MODE_ONE) led <= 1'b0;
      end else if (step) begin
        led   <= shift[MASK_BITS-1];
        shift <= {shift[MASK_BITS-2:0], shift[MASK_BITS-1]};
        if (mode == MODE_LOOP) begin
          pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
        end else begin
          pos <= pos + 1'b1;
          if (pos == POS_LAST) done <= 1'b1;
        end
      end else if (tick) begin
        led <= 1'b0;
      end
    end

    assign shift_all[i] = shift;
    assign mode_all[i]  = mode;
    assign done_all[i]  = done;
    assign o_led[i]     = led;
  end

  assign rd_data = sel ? MASK_BITS'({done_all[ch], mode_all[ch]}) : shift_all[ch];

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      ACK_O <= acc;
      if (acc) DAT_O <= rd_data;
    end
  end
endmodule

// File: tb/tb_wish_blinky_multi.sv
// Randomized bench for wish_blinky_multi with a step-count behavioural model
// plus directed literal checks for the LOOP, ONESHOT, handshake and collision cases.
module tb_wish_blinky_multi;
  localparam int CHB = 1, MB = 8, DB = 4, TOP = 3, NCH = 2;

  logic clk = 0, rst = 1, stb = 0, we = 0;
  logic [CHB:0]    adr = '0;
  logic [MB-1:0]   dat_i = '0;
  logic [MB-1:0]   dat_o;
  logic            ack;
  logic [NCH-1:0]  led;

  wish_blinky_multi #(.CH_BITS(CHB), .MASK_BITS(MB), .DIV_BITS(DB), .DIV_TOP(TOP)) dut (
    .CLK_I(clk), .RST_I(rst), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat_i), .DAT_O(dat_o), .ACK_O(ack), .o_led(led)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel keeps its current mask, a count of steps since the last
  // write, and its LED; ONESHOT is "done" once MB steps have been taken.
  logic [MB-1:0] m_shift [NCH];
  int            m_n     [NCH];
  logic [1:0]    m_mode  [NCH];
  logic          m_led   [NCH];
  int            mcnt;
  logic          mack;
  logic [MB-1:0] mdat;
  logic [CHB-1:0] ai;
  wire m_tick = (mcnt == TOP);
  wire m_acc  = stb && !mack;
  assign ai = adr[CHB-1:0];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 0; mack <= 0; mdat <= '0;
      for (int c = 0; c < NCH; c++) begin
        m_shift[c] <= '0; m_n[c] <= 0; m_mode[c] <= 2'd0; m_led[c] <= 1'b0;
      end
    end else begin
      mcnt <= m_tick ? 0 : mcnt + 1;
      mack <= m_acc;
      if (m_acc)
        mdat <= adr[CHB] ? {5'b0, (m_mode[ai] == 2'd2 && m_n[ai] >= MB), m_mode[ai]}
                         : m_shift[ai];
      for (int c = 0; c < NCH; c++) begin
        if (m_acc && we && int'(ai) == c) begin
          m_n[c] <= 0;
          if (!adr[CHB]) begin
            m_shift[c] <= dat_i; m_led[c] <= 1'b0;
          end else begin
            m_mode[c] <= dat_i[1:0];
            if (dat_i[1:0] == 2'd0 || dat_i[1:0] == 2'd3) m_led[c] <= 1'b0;
          end
        end else if (m_tick) begin
          if (m_mode[c] == 2'd1 || (m_mode[c] == 2'd2 && m_n[c] < MB)) begin
            m_led[c]   <= m_shift[c][MB-1];
            m_shift[c] <= (m_shift[c] << 1) | (m_shift[c] >> (MB-1));
            m_n[c]     <= m_n[c] + 1;
          end else begin
            m_led[c] <= 1'b0;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) begin
      for (int c = 0; c < NCH; c++) chk("model_led", led[c], m_led[c]);
      chk("model_ack", ack, mack);
      chk("model_dat_o", dat_o, mdat);
    end
  end

  task automatic bus(input logic w, input logic [CHB:0] a, input logic [MB-1:0] d,
                     output logic [MB-1:0] rd);
    @(negedge clk); stb = 1; we = w; adr = a; dat_i = d;
    @(negedge clk); chk("bus_ack", ack, 1); rd = dat_o; stb = 0; we = 0;
  endtask
  task automatic wr(input logic [CHB:0] a, input logic [MB-1:0] d);
    logic [MB-1:0] t; bus(1'b1, a, d, t);
  endtask
  task automatic rd(input logic [CHB:0] a, output logic [MB-1:0] v);
    bus(1'b0, a, '0, v);
  endtask
  // Returns on the falling edge right after a tick edge.
  task automatic wait_tick();
    for (int i = 0; i < TOP + 2; i++) begin
      @(negedge clk);
      if (mcnt == 0) return;
    end
    chk("tick_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MB-1:0] v, pat;
    int nz;
    repeat (2) @(negedge clk);
    #2 rst = 0; chk_en = 1;

    // Reset / idle, with something live before the pulse
    wr(2'd0, 8'hFF); wr(2'd2, 8'h01);
    repeat (3) wait_tick();
    rd(2'd0, v);
    @(negedge clk); #2 rst = 1;
    #1 chk("rst_led", led, 0); chk("rst_ack", ack, 0); chk("rst_dat", dat_o, 0);
    @(negedge clk); #2 rst = 0;
    for (int a = 0; a < 4; a++) begin rd(a[CHB:0], v); chk("rst_reg", v, 0); end
    nz = 0;
    repeat (100) begin @(negedge clk); if (led != 0) nz++; end
    chk("idle_led", nz, 0);

    // LOOP pattern A5 on ch0
    pat = 8'hA5;
    wr(2'd0, pat); wr(2'd2, 8'h01);
    for (int k = 0; k < 16; k++) begin
      wait_tick();
      chk("loop_bit", led[0], pat[7 - (k % 8)]);
      chk("loop_ch1", led[1], 0);
    end

    // ONESHOT F0 on ch1, then re-arm
    wr(2'd1, 8'hF0); wr(2'd3, 8'h02);
    for (int k = 0; k < 10; k++) begin wait_tick(); chk("oneshot_bit", led[1], k < 4); end
    rd(2'd3, v); chk("mode_done", v, 8'h06);
    wr(2'd3, 8'h02);
    for (int k = 0; k < 10; k++) begin
      wait_tick();
      chk("replay_bit", led[1], k < 4);
      if (k == 3) begin rd(2'd3, v); chk("mode_run", v, 8'h02); end
    end

    // Held strobe: acked every second cycle
    @(negedge clk); stb = 1; we = 0; adr = 2'd0;
    for (int i = 0; i < 6; i++) begin chk("hold_ack", ack, i % 2); @(negedge clk); end
    stb = 0;

    // Write-then-read of a running LOOP mask after exactly two ticks
    wait_tick(); wr(2'd0, 8'h3C);
    wait_tick(); wait_tick();
    rd(2'd0, v); chk("mask_rot2", v, 8'hF0);

    // Collision: ch0 mask write on the tick edge, ch1 freshly in LOOP on FF
    wr(2'd3, 8'h00); wr(2'd1, 8'hFF); wr(2'd3, 8'h01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mcnt == TOP && !ack) break;
    end
    chk("coll_align", mcnt, TOP);
    chk("coll_ch1_pre", led[1], 0);
    stb = 1; we = 1; adr = 2'd0; dat_i = 8'h81;
    @(negedge clk); chk("coll_ack", ack, 1); stb = 0; we = 0;
    chk("coll_led0", led[0], 0);
    chk("coll_ch1_step", led[1], 1);
    wait_tick(); chk("coll_next", led[0], 1);

    // Reset mid-pattern with both channels in LOOP
    repeat (3) wait_tick();
    rd(2'd1, v);
    @(negedge clk); #3 rst = 1;
    #1 chk("rst2_led", led, 0); chk("rst2_ack", ack, 0); chk("rst2_dat", dat_o, 0);
    #10 rst = 0;
    rd(2'd2, v); chk("rst2_mode0", v, 0);
    rd(2'd3, v); chk("rst2_mode1", v, 0);
    nz = 0;
    repeat (40) begin @(negedge clk); if (led != 0) nz++; end
    chk("rst2_idle", nz, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [CHB:0] a;
      logic [MB-1:0] d;
      a = CHB'(0) + 2'($urandom_range(0, 3));
      d = a[CHB] ? 8'($urandom_range(0, 3)) : 8'($urandom);
      bus(1'($urandom_range(0, 1)), a, d, v);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
